// File: rtl/led_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the multi-channel LED pattern generator:
//   - led_mode_e  : per-channel pattern selector (OFF / ON / BLINK / BREATHE)
//   - cfg_state_e : states of the config write handshake
//   - MODE_W      : width of the mode field on the config port
//   - PERIOD_W    : width of the period field and the per-channel phase counter
//   - chan_width  : channel-select width for a given LED count (never below 1)
// ---------------------------------------------------------------------------
package led_pkg;

   localparam int MODE_W   = 2;
   localparam int PERIOD_W = 16;

   typedef enum logic [MODE_W-1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_COMMIT = 2'd2
   } cfg_state_e;

   // A single LED still needs a one-bit channel field so the port never
   // collapses to zero width.
   function automatic int chan_width(input int num_leds);
      return (num_leds <= 2) ? 1 : $clog2(num_leds);
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
// Config write port of the LED pattern generator (valid/ready handshake).
//   cfg_valid  : write request (master -> slave)
//   cfg_ready  : slave can accept a write (slave -> master)
//   cfg_chan   : target channel, CHAN_W bits
//   cfg_mode   : 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//   cfg_period : BLINK half-period / BREATHE step interval in ticks
//   cfg_duty   : brightness or BREATHE peak level, PWM_BITS bits
// Modports: master drives the request, slave (the generator) answers ready.
// ---------------------------------------------------------------------------
interface led_pattern_gen_if #(
   parameter int CHAN_W   = 2,
   parameter int PWM_BITS = 8
);
   import led_pkg::*;

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CHAN_W-1:0]   cfg_chan;
   logic [MODE_W-1:0]   cfg_mode;
   logic [PERIOD_W-1:0] cfg_period;
   logic [PWM_BITS-1:0] cfg_duty;

   modport master (
      output cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
      output cfg_ready
   );

endinterface

// File: rtl/led_pattern_gen_channel.sv
// ---------------------------------------------------------------------------
// led_channel
// One LED channel: holds its committed mode/period/duty and the pattern state
// (tick phase counter, blink phase, breathe level and direction), and drives a
// registered LED output.
//   clk50m, rst : clock, asynchronous active-high reset
//   tick        : one-cycle pattern timebase pulse
//   pwm_cnt     : shared free-running PWM counter
//   load        : commit strobe, loads cfg_* and restarts the pattern
//   cfg_mode, cfg_period, cfg_duty : configuration to load
//   led         : registered LED drive
// ---------------------------------------------------------------------------
module led_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk50m,
   input  logic                rst,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                load,
   input  led_mode_e           cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic                led
);

   led_mode_e           mode;
   logic [PERIOD_W-1:0] period;
   logic [PWM_BITS-1:0] duty;
   logic [PERIOD_W-1:0] phase;
   logic                blink_st;
   logic [PWM_BITS-1:0] level;
   logic                dir_up;

   logic [PERIOD_W-1:0] last_phase;
   logic                step;
   logic                next_led;

   // All-ones duty must mean solid on, which a plain "count < duty" compare
   // could never reach.
   function automatic logic pwm_on(input logic [PWM_BITS-1:0] d,
                                   input logic [PWM_BITS-1:0] c);
      return (d == '1) || (c < d);
   endfunction

   // A period of 0 behaves like 1, so the phase wraps on every tick. Comparing
   // against period-1 keeps the full 16-bit range usable without overflow.
   assign last_phase = (period == '0) ? '0 : period - 1'b1;
   assign step       = tick && (phase == last_phase);

   // Next LED value for the current mode; it is registered below so the pin
   // never sees combinational glitches.
   always_comb begin
      next_led = 1'b0;
      case (mode)
         LED_OFF:     next_led = 1'b0;
         LED_ON:      next_led = pwm_on(duty, pwm_cnt);
         LED_BLINK:   next_led = blink_st && pwm_on(duty, pwm_cnt);
         LED_BREATHE: next_led = pwm_on(level, pwm_cnt);
         default:     next_led = 1'b0;
      endcase
   end

   // Pattern state. A commit restarts the pattern from its beginning (off
   // phase, level 0, rising). Otherwise the phase counter advances on every
   // tick and each wrap is one pattern step: the blink phase toggles and the
   // breathe level moves one count, turning round at the peak and at zero so
   // the level changes on every step. A zero peak parks the level at 0.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         mode     <= LED_OFF;
         period   <= '0;
         duty     <= '0;
         phase    <= '0;
         blink_st <= 1'b0;
         level    <= '0;
         dir_up   <= 1'b1;
         led      <= 1'b0;
      end else begin
         led <= next_led;
         if (load) begin
            mode     <= cfg_mode;
            period   <= cfg_period;
            duty     <= cfg_duty;
            phase    <= '0;
            blink_st <= 1'b0;
            level    <= '0;
            dir_up   <= 1'b1;
         end else if (tick) begin
            phase <= step ? '0 : phase + 1'b1;
            if (step) begin
               blink_st <= ~blink_st;
               if (mode == LED_BREATHE) begin
                  if (dir_up) begin
                     if (level < duty) begin
                        level <= level + 1'b1;
                        if ((level + 1'b1) == duty) begin
                           dir_up <= 1'b0;
                        end
                     end
                  end else begin
                     if (level != '0) begin
                        level <= level - 1'b1;
                        if (level == PWM_BITS'(1)) begin
                           dir_up <= 1'b1;
                        end
                     end else begin
                        dir_up <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED driver for the Pi5-Artix50T hat. Each of NUM_LEDS outputs
// runs OFF, ON (PWM dimmed), BLINK or BREATHE. Configuration arrives through a
// valid/ready write port and takes effect only on a pattern tick boundary.
//   clk50m : system clock (CLK_HZ)
//   rst    : asynchronous active-high reset
//   cfg    : config write port (led_pattern_gen_if.slave)
//   led    : registered LED drive, bit i = channel i
// Parameters: CLK_HZ, TICK_HZ (PRESCALE = CLK_HZ/TICK_HZ >= 2), NUM_LEDS
// (1..16), PWM_BITS (4..12), CHAN_W (channel field width, may be widened).
// ---------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int NUM_LEDS = 4,
   parameter int PWM_BITS = 8,
   parameter int CHAN_W   = chan_width(NUM_LEDS)
) (
   input  logic                 clk50m,
   input  logic                 rst,
   led_pattern_gen_if.slave     cfg,
   output logic [NUM_LEDS-1:0]  led
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);

   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;

   cfg_state_e          state;
   logic                ready_q;
   logic [CHAN_W-1:0]   pend_chan;
   led_mode_e           pend_mode;
   logic [PERIOD_W-1:0] pend_period;
   logic [PWM_BITS-1:0] pend_duty;
   logic                commit;

   // Prescaler. The tick is registered, so it is high during the cycle in
   // which the count has just wrapped back to 0.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (pre_cnt == PRE_W'(PRESCALE - 1)) begin
         pre_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   // Free-running PWM counter shared by every channel so all LEDs dim in phase.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Write handshake. A write is captured into the single pending register
   // and ready drops. PEND only looks at the tick, so a write accepted on a
   // tick cycle waits for the next one. COMMIT is the cycle in which the new
   // settings are already live in the channel; ready returns after it.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         ready_q     <= 1'b1;
         pend_chan   <= '0;
         pend_mode   <= LED_OFF;
         pend_period <= '0;
         pend_duty   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg.cfg_valid && ready_q) begin
                  pend_chan   <= cfg.cfg_chan;
                  pend_mode   <= led_mode_e'(cfg.cfg_mode);
                  pend_period <= cfg.cfg_period;
                  pend_duty   <= cfg.cfg_duty;
                  ready_q     <= 1'b0;
                  state       <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (tick) begin
                  state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg.cfg_ready = ready_q;

   // The channels load on the same tick that moves PEND to COMMIT.
   assign commit = (state == ST_PEND) && tick;

   // One channel per LED. An out-of-range channel number matches no instance,
   // so such a write completes its handshake and is simply dropped.
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
      led_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_chan (
         .clk50m     (clk50m),
         .rst        (rst),
         .tick       (tick),
         .pwm_cnt    (pwm_cnt),
         .load       (commit && (pend_chan == CHAN_W'(i))),
         .cfg_mode   (pend_mode),
         .cfg_period (pend_period),
         .cfg_duty   (pend_duty),
         .led        (led[i])
      );
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen with PRESCALE=10, four channels and
// 4-bit PWM. Every cycle the LED vector and cfg_ready are compared against a
// closed-form reference built from each channel's committed settings and its
// commit cycle. Expected ready-rise cycles go into a queue when a write is
// driven and are popped when cfg_ready actually rises. A table of ON/OFF
// writes checks high-time per 16 clocks; hand-written sequences cover BLINK,
// BREATHE, accept-on-tick, invalid channel, held valid and mid-pattern reset.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 100;
   localparam int NUM_LEDS = 4;
   localparam int PWM_BITS = 4;
   localparam int CHAN_W   = 3;
   localparam int PRESC    = 10;
   localparam int PWM_MAX  = 15;

   typedef struct {
      int chan;
      int mode;
      int per;
      int duty;
      int exp_hi;
   } vec_t;

   logic                clk50m;
   logic                rst;
   logic [NUM_LEDS-1:0] led;

   int applied;
   int miscompares;
   int cyc;

   int m_mode [NUM_LEDS];
   int m_per  [NUM_LEDS];
   int m_duty [NUM_LEDS];
   int m_t    [NUM_LEDS];

   bit p_valid;
   int p_acc;
   int p_t;
   int p_chan;
   int p_mode;
   int p_per;
   int p_duty;
   int exp_rise_q [$];
   logic prev_ready;

   vec_t vecs [6];

   led_pattern_gen_if #(.CHAN_W(CHAN_W), .PWM_BITS(PWM_BITS)) cfg_bus ();

   led_pattern_gen #(
      .CLK_HZ   (CLK_HZ),
      .TICK_HZ  (TICK_HZ),
      .NUM_LEDS (NUM_LEDS),
      .PWM_BITS (PWM_BITS),
      .CHAN_W   (CHAN_W)
   ) dut (
      .clk50m (clk50m),
      .rst    (rst),
      .cfg    (cfg_bus),
      .led    (led)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk50m = 1'b0;
      forever #5 clk50m = ~clk50m;
   end

   function automatic bit pwmOn(input int d, input int c);
      return (d == PWM_MAX) || (c < d);
   endfunction

   // Expected LED bit for channel ch at cycle c. The LED register shows the
   // pattern state of cycle c-1; k is the number of ticks that have taken
   // effect since the commit on tick m_t.
   function automatic bit expBit(input int ch, input int c);
      int x, pw, k, p, s, n, lvl;
      x  = c - 1;
      pw = x % 16;
      k  = (x - m_t[ch] - 1) / PRESC;
      p  = (m_per[ch] == 0) ? 1 : m_per[ch];
      case (m_mode[ch])
         1: return pwmOn(m_duty[ch], pw);
         2: begin
            s = k / p;
            return ((s % 2) == 1) && pwmOn(m_duty[ch], pw);
         end
         3: begin
            if (m_duty[ch] == 0) return 1'b0;
            n   = 2 * m_duty[ch];
            s   = (k / p) % n;
            lvl = (s <= m_duty[ch]) ? s : n - s;
            return pwmOn(lvl, pw);
         end
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string name, input int got, input int exp);
      applied++;
      if (got != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NUM_LEDS; i++) begin
         m_mode[i] = 0;
         m_per[i]  = 0;
         m_duty[i] = 0;
         m_t[i]    = 0;
      end
      p_valid    = 1'b0;
      cyc        = 0;
      prev_ready = 1'b1;
      exp_rise_q.delete();
   endtask

   task automatic checkOutput();
      logic [NUM_LEDS-1:0] e;
      bit er;
      int r;
      if (p_valid && (cyc == p_t + 2)) begin
         if (p_chan < NUM_LEDS) begin
            m_mode[p_chan] = p_mode;
            m_per[p_chan]  = p_per;
            m_duty[p_chan] = p_duty;
            m_t[p_chan]    = p_t;
         end
         p_valid = 1'b0;
      end
      er = !(p_valid && (cyc > p_acc) && (cyc <= p_t + 1));
      for (int i = 0; i < NUM_LEDS; i++) begin
         e[i] = expBit(i, cyc);
      end
      check("led", int'(led), int'(e));
      check("cfg_ready", int'(cfg_bus.cfg_ready), int'(er));
      if (cfg_bus.cfg_ready && !prev_ready) begin
         if (exp_rise_q.size() == 0) begin
            check("ready_rise_unexpected", cyc, -1);
         end else begin
            r = exp_rise_q.pop_front();
            check("ready_rise_cycle", cyc, r);
         end
      end
      prev_ready = cfg_bus.cfg_ready;
   endtask

   task automatic stepCycle();
      @(negedge clk50m);
      cyc++;
      checkOutput();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic countHigh(input int ch, input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         stepCycle();
         hi += int'(led[ch]);
      end
   endtask

   task automatic waitReady();
      for (int i = 0; i < 40 && !(cfg_bus.cfg_ready && !p_valid); i++) stepCycle();
      check("ready_timeout", int'(cfg_bus.cfg_ready && !p_valid), 1);
   endtask

   // Drives one write at the current (ready) cycle and records the expected
   // commit tick. With hold set, cfg_valid stays high through PEND while the
   // fields are scrambled, and drops in the cycle ready comes back.
   task automatic applyStimulus(input int ch, input int mode, input int per,
                                input int duty, input bit hold);
      cfg_bus.cfg_valid  = 1'b1;
      cfg_bus.cfg_chan   = CHAN_W'(ch);
      cfg_bus.cfg_mode   = MODE_W'(mode);
      cfg_bus.cfg_period = PERIOD_W'(per);
      cfg_bus.cfg_duty   = PWM_BITS'(duty);
      p_valid = 1'b1;
      p_acc   = cyc;
      p_t     = (cyc / PRESC + 1) * PRESC;
      p_chan  = ch;
      p_mode  = mode;
      p_per   = per;
      p_duty  = duty;
      exp_rise_q.push_back(p_t + 2);
      stepCycle();
      if (!hold) begin
         cfg_bus.cfg_valid = 1'b0;
      end else begin
         cfg_bus.cfg_chan   = CHAN_W'(3);
         cfg_bus.cfg_mode   = MODE_W'(1);
         cfg_bus.cfg_period = PERIOD_W'(0);
         cfg_bus.cfg_duty   = PWM_BITS'(PWM_MAX);
         for (int i = 0; i < 40 && !cfg_bus.cfg_ready; i++) stepCycle();
         cfg_bus.cfg_valid = 1'b0;
      end
   endtask

   // Asserts reset between clock edges, checks the asynchronous clear, then
   // releases on a falling edge so the next rising edge is cycle 1.
   task automatic doReset(input int ncyc);
      #1 rst = 1'b1;
      #1;
      check("reset_led_async", int'(led), 0);
      check("reset_ready_async", int'(cfg_bus.cfg_ready), 1);
      cfg_bus.cfg_valid = 1'b0;
      repeat (ncyc) @(negedge clk50m);
      rst = 1'b0;
      modelReset();
   endtask

   initial begin
      int hi;
      vecs[0] = '{chan: 3, mode: 1, per: 0, duty: 0,  exp_hi: 0};
      vecs[1] = '{chan: 3, mode: 1, per: 0, duty: 1,  exp_hi: 1};
      vecs[2] = '{chan: 3, mode: 1, per: 0, duty: 9,  exp_hi: 9};
      vecs[3] = '{chan: 3, mode: 1, per: 0, duty: 15, exp_hi: 16};
      vecs[4] = '{chan: 3, mode: 0, per: 5, duty: 15, exp_hi: 0};
      vecs[5] = '{chan: 2, mode: 1, per: 0, duty: 7,  exp_hi: 7};

      applied     = 0;
      miscompares = 0;
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_chan   = '0;
      cfg_bus.cfg_mode   = '0;
      cfg_bus.cfg_period = '0;
      cfg_bus.cfg_duty   = '0;
      modelReset();
      rst = 1'b0;
      #1;

      doReset(5);
      checkOutput();
      runCycles(200);

      waitReady();
      applyStimulus(1, 1, 0, 15, 1'b0);
      waitReady();
      countHigh(1, 50, hi);
      check("on_solid_hi50", hi, 50);

      foreach (vecs[v]) begin
         waitReady();
         applyStimulus(vecs[v].chan, vecs[v].mode, vecs[v].per, vecs[v].duty, 1'b0);
         waitReady();
         countHigh(vecs[v].chan, 16, hi);
         check($sformatf("vec%0d_hi16", v), hi, vecs[v].exp_hi);
      end

      waitReady();
      applyStimulus(0, 2, 3, 15, 1'b0);
      waitReady();
      countHigh(0, 120, hi);
      check("blink_full_hi120", hi, 60);

      waitReady();
      applyStimulus(0, 2, 3, 4, 1'b0);
      waitReady();
      runCycles(130);

      waitReady();
      applyStimulus(2, 3, 1, 3, 1'b0);
      waitReady();
      runCycles(140);

      waitReady();
      for (int i = 0; i < PRESC && (cyc % PRESC) != 0; i++) stepCycle();
      applyStimulus(3, 1, 0, 5, 1'b0);
      waitReady();
      countHigh(3, 16, hi);
      check("tick_accept_hi16", hi, 5);

      waitReady();
      applyStimulus(5, 1, 0, 15, 1'b1);
      runCycles(40);

      waitReady();
      applyStimulus(3, 1, 0, 15, 1'b0);
      runCycles(3);
      doReset(5);
      checkOutput();
      runCycles(40);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
